// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU normalization constants, FSM states and step codes
package fpu_pkg;

   localparam int N_MANT     = 25;
   localparam int N_EXP      = 8;
   localparam int EXP_MAX    = 2**N_EXP - 1;
   localparam int CARRY_BIT  = N_MANT - 1;
   localparam int HIDDEN_BIT = N_MANT - 2;

   typedef enum logic {IDLE, SHIFT} state_t;

   typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

   // How the current SHIFT evaluation terminates, FIN_NONE while still iterating.
   typedef enum logic [2:0] {
      FIN_NONE,
      FIN_ZERO,
      FIN_OVF,
      FIN_UNF,
      FIN_NORM
   } fin_t;

endpackage

// File: rtl/norm_seq_ctrl_if.sv
// rtl/norm_seq_ctrl_if.sv - start/done request-result bundle of the normalizer
interface norm_seq_ctrl_if #(
   parameter int N_mant = 25,
   parameter int N_exp  = 8
);
   localparam int CW = $clog2(N_mant);

   logic              start;
   logic              ready;
   logic [N_mant-1:0] mant_in;
   logic [N_exp-1:0]  exp_in;
   logic              done;
   logic [N_mant-2:0] mant_out;
   logic              sticky;
   logic [N_exp-1:0]  exp_out;
   logic              zero;
   logic              overflow;
   logic              underflow;
   logic [CW-1:0]     shift_cnt;

   modport master (
      output start, mant_in, exp_in,
      input  ready, done, mant_out, sticky, exp_out, zero, overflow, underflow, shift_cnt
   );

   modport slave (
      input  start, mant_in, exp_in,
      output ready, done, mant_out, sticky, exp_out, zero, overflow, underflow, shift_cnt
   );

endinterface

// File: rtl/norm_step.sv
// rtl/norm_step.sv - combinational one-position mantissa shift with exponent adjust
module norm_step
   import fpu_pkg::*;
#(
   parameter int N_mant = N_MANT,
   parameter int N_exp  = N_EXP
) (
   input  logic [N_mant-1:0] mant,
   input  logic [N_exp:0]    exp,
   input  dir_t              dir,
   output logic [N_mant-1:0] mant_nxt,
   output logic [N_exp:0]    exp_nxt,
   output logic              shifted_out
);

   always_comb begin
      mant_nxt    = mant;
      exp_nxt     = exp;
      shifted_out = 1'b0;
      if (dir == DIR_RIGHT) begin
         mant_nxt    = {1'b0, mant[N_mant-1:1]};
         exp_nxt     = exp + 1'b1;
         shifted_out = mant[0];
      end else begin
         mant_nxt    = {mant[N_mant-2:0], 1'b0};
         exp_nxt     = exp - 1'b1;
      end
   end

endmodule

// File: rtl/norm_seq_ctrl.sv
// rtl/norm_seq_ctrl.sv - iterative post-add normalizer, one shift per clock
module norm_seq_ctrl
   import fpu_pkg::*;
#(
   parameter int N_mant = N_MANT,
   parameter int N_exp  = N_EXP
) (
   input  logic           clk,
   input  logic           rst,
   norm_seq_ctrl_if.slave bus
);

   localparam int CARRY  = N_mant - 1;
   localparam int HIDDEN = N_mant - 2;
   localparam int CW     = $clog2(N_mant);
   localparam logic [N_exp:0] EXP_LIM = {1'b0, {N_exp{1'b1}}};
   localparam logic [N_exp:0] EXP_ONE = {{N_exp{1'b0}}, 1'b1};

   state_t            state, state_nxt;
   fin_t              fin;
   logic              shift_en;
   dir_t              shift_dir;

   logic [N_mant-1:0] w_mant;
   logic [N_exp:0]    w_exp;
   logic              w_sticky;
   logic [CW-1:0]     w_cnt;

   logic [N_mant-1:0] step_mant;
   logic [N_exp:0]    step_exp;
   logic              step_lsb;

   logic              done_q;
   logic [N_mant-2:0] mant_q;
   logic              sticky_q;
   logic [N_exp-1:0]  exp_q;
   logic              zero_q;
   logic              ovf_q;
   logic              unf_q;
   logic [CW-1:0]     cnt_q;

   norm_step #(
      .N_mant (N_mant),
      .N_exp  (N_exp)
   ) u_step (
      .mant        (w_mant),
      .exp         (w_exp),
      .dir         (shift_dir),
      .mant_nxt    (step_mant),
      .exp_nxt     (step_exp),
      .shifted_out (step_lsb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Overflow is reported on the evaluation after the right shift that reached all-ones.
   always_comb begin
      state_nxt = state;
      fin       = FIN_NONE;
      shift_en  = 1'b0;
      shift_dir = DIR_LEFT;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_mant == '0) begin
               fin = FIN_ZERO;
            end else if (w_exp >= EXP_LIM) begin
               fin = FIN_OVF;
            end else if (w_mant[CARRY]) begin
               shift_en  = 1'b1;
               shift_dir = DIR_RIGHT;
            end else if (!w_mant[HIDDEN]) begin
               if (w_exp > EXP_ONE) shift_en = 1'b1;
               else                 fin      = FIN_UNF;
            end else begin
               fin = FIN_NORM;
            end
            if (fin != FIN_NONE) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_mant   <= '0;
         w_exp    <= '0;
         w_sticky <= 1'b0;
         w_cnt    <= '0;
         done_q   <= 1'b0;
         mant_q   <= '0;
         sticky_q <= 1'b0;
         exp_q    <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE && bus.start) begin
            w_mant   <= bus.mant_in;
            w_exp    <= {1'b0, bus.exp_in};
            w_sticky <= 1'b0;
            w_cnt    <= '0;
         end
         if (shift_en) begin
            w_mant   <= step_mant;
            w_exp    <= step_exp;
            w_sticky <= w_sticky | step_lsb;
            w_cnt    <= w_cnt + 1'b1;
         end
         if (fin != FIN_NONE) begin
            done_q   <= 1'b1;
            sticky_q <= w_sticky;
            cnt_q    <= w_cnt;
            zero_q   <= (fin == FIN_ZERO);
            ovf_q    <= (fin == FIN_OVF);
            unf_q    <= (fin == FIN_UNF);
            mant_q   <= (fin == FIN_NORM || fin == FIN_UNF) ? w_mant[N_mant-2:0] : '0;
            if (fin == FIN_NORM)     exp_q <= w_exp[N_exp-1:0];
            else if (fin == FIN_OVF) exp_q <= '1;
            else                     exp_q <= '0;
         end
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.done      = done_q;
   assign bus.mant_out  = mant_q;
   assign bus.sticky    = sticky_q;
   assign bus.exp_out   = exp_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.shift_cnt = cnt_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// tb/tb_norm_seq_ctrl.sv - directed-vector bench for norm_seq_ctrl
module tb_norm_seq_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   norm_seq_ctrl_if #(.N_mant(25), .N_exp(8)) bus ();

   norm_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [23:0] e_mant, input logic [7:0] e_exp,
                                input logic e_st, input logic e_z, input logic e_o, input logic e_u,
                                input int e_cnt);
      check_eq({tag, "_mant"}, 32'(bus.mant_out), 32'(e_mant));
      check_eq({tag, "_exp"}, 32'(bus.exp_out), 32'(e_exp));
      check_eq({tag, "_sticky"}, 32'(bus.sticky), 32'(e_st));
      check_eq({tag, "_zero"}, 32'(bus.zero), 32'(e_z));
      check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(e_o));
      check_eq({tag, "_unf"}, 32'(bus.underflow), 32'(e_u));
      check_eq({tag, "_cnt"}, 32'(bus.shift_cnt), 32'(e_cnt));
   endtask

   // Drives start at #1 after an edge, so calling this right after a done keeps requests back-to-back.
   task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e, input bit poke,
                         input int e_lat, input logic [23:0] e_mant, input logic [7:0] e_exp,
                         input logic e_st, input logic e_z, input logic e_o, input logic e_u,
                         input int e_cnt);
      int lat = 0;
      bus.start   = 1'b1;
      bus.mant_in = m;
      bus.exp_in  = e;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.mant_in = 25'h1555555;
      bus.exp_in  = 8'h33;
      check_eq({tag, "_busy_ready"}, 32'(bus.ready), 32'd0);
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (bus.done) lat = n;
         if (poke && n == 3) begin
            bus.start   = 1'b1;
            bus.mant_in = 25'h0;
            bus.exp_in  = 8'd90;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check_eq({tag, "_latency"}, 32'(lat), 32'(e_lat));
      check_eq({tag, "_done_ready"}, 32'(bus.ready), 32'd1);
      check_outputs(tag, e_mant, e_exp, e_st, e_z, e_o, e_u, e_cnt);
   endtask

   initial begin
      int pulses;
      bus.start   = 1'b0;
      bus.mant_in = '0;
      bus.exp_in  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(bus.ready), 32'd1);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_outputs("rst", 24'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("norm", 25'h0800000, 8'd127, 1'b0, 1, 24'h800000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_op("carry", 25'h1800001, 8'd127, 1'b0, 2, 24'hC00000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      @(posedge clk); #1;
      run_op("left", 25'h0000100, 8'd127, 1'b1, 16, 24'h800000, 8'd112, 1'b0, 1'b0, 1'b0, 1'b0, 15);
      repeat (2) @(posedge clk);
      #1;
      check_eq("hold_done", 32'(bus.done), 32'd0);
      check_outputs("hold", 24'h800000, 8'd112, 1'b0, 1'b0, 1'b0, 1'b0, 15);

      run_op("unf", 25'h0000001, 8'd5, 1'b0, 5, 24'h000010, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
      run_op("ovf", 25'h1000000, 8'd254, 1'b0, 2, 24'h000000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      run_op("zero", 25'h0000000, 8'd90, 1'b0, 1, 24'h000000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      run_op("carry2", 25'h1800001, 8'd127, 1'b0, 2, 24'hC00000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1);

      bus.start   = 1'b1;
      bus.mant_in = 25'h0000100;
      bus.exp_in  = 8'd127;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("abort_ready", 32'(bus.ready), 32'd1);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      check_outputs("abort", 24'h0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      check_eq("abort_no_done", 32'(pulses), 32'd0);
      check_eq("abort_idle_ready", 32'(bus.ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/norm_seq_ctrl.md
Name: norm_seq_ctrl

Overview:
Iterative normalization controller for the FPU post-add/sub path. It accepts an unnormalized mantissa, with a carry bit at the MSB, and a biased exponent. It drives a single-step shift-and-adjust datapath one step per clock until the mantissa is normalized or an exponent limit is hit. It returns the normalized result, sticky bit and status flags through a start/done handshake to the rounding stage.

Parameters:
N_mant, 25, input mantissa width; bit N_mant-1 = carry, bit N_mant-2 = hidden bit
N_exp, 8, biased exponent width; all-ones = Inf/NaN code

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted only when ready=1
ready  out  1  high in IDLE
mant_in  in  N_mant  unnormalized mantissa
exp_in  in  N_exp  biased exponent
done  out  1  one-cycle pulse, result valid
mant_out  out  N_mant-1  normalized mantissa incl. hidden bit
sticky  out  1  OR of bits shifted out on right shift
exp_out  out  N_exp  adjusted exponent
zero  out  1  mantissa_in was zero
overflow  out  1  exponent reached all-ones
underflow  out  1  stopped at exp_out=0 before normalized (denormal)
shift_cnt  out  clog2(N_mant)  number of shifts performed

Behaviour:
- Reset, asynchronous: state=IDLE, ready=1, done=0. All result outputs and flags are 0.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at edge T: capture mant_in/exp_in into working regs; clear sticky/flags/shift_cnt; go to SHIFT; ready=0.
  - start=0: hold the last result.
- SHIFT: each edge evaluates the working regs in this priority order:
  1. mant==0 → zero=1, exp_out=0, mant_out=0 → IDLE.
  2. carry bit=1 → right shift 1. The shifted-out bit is ORed into sticky. exp+1.
     - If exp+1 == all-ones: overflow=1, mant_out=0, exp_out=all-ones → IDLE.
     - Otherwise stay in SHIFT.
  3. hidden bit=0 and exp>1 → left shift 1, zero fill, exp-1; stay in SHIFT.
  4. hidden bit=0 and exp<=1 → underflow=1, exp_out=0, mant_out=current bits → IDLE.
  5. Normalized (carry=0, hidden=1) → output regs → IDLE.
- Every shift increments shift_cnt.
- done is high for exactly the cycle after the terminating edge; ready returns high in that same cycle.
- Latency: done high after edge T+1+k, where k = number of shifts.
  - k≤1 for right shifts; a right shift can occur only once, since the carry is cleared.
  - k≤N_mant-2 for left shifts.
- start while ready=0 is ignored; there is no queueing.
- Back-to-back: start may be asserted in the done cycle and is accepted at that edge.
- Outputs hold stable from done until the next accepted start's terminating edge.
- Reset mid-SHIFT aborts the operation. No done is issued. All outputs return to reset values.
- Exponent arithmetic is done in N_exp+1 bits internally. exp_in=all-ones is not legal input; behaviour is don't-care.

Decomposition:
- Shared package fpu_pkg holds:
  - N_MANT/N_EXP defaults
  - EXP_MAX = 2**N_EXP-1
  - state enum {IDLE, SHIFT}
  - bit-index constants CARRY_BIT = N_MANT-1, HIDDEN_BIT = N_MANT-2
- One sub-module, norm_step: purely combinational single-step shifter.
  - Inputs: mant, exp, dir.
  - Outputs: shifted mant, adjusted exp, shifted-out lsb.
- norm_seq_ctrl holds the FSM, working regs, shift counter and flag logic.

Test Plan (N_mant=25, N_exp=8, start at edge T):
- Already normalized: mant_in=0x0800000, exp_in=127 → done at T+1; mant_out=0x800000, exp_out=127, sticky=0, shift_cnt=0.
- Carry: mant_in=0x1800001, exp_in=127 → done at T+2; mant_out=0xC00000, sticky=1, exp_out=128, shift_cnt=1.
- Left shifts: mant_in=0x0000100, exp_in=127 → done at T+16; mant_out=0x800000, exp_out=112, shift_cnt=15.
- Underflow: mant_in=0x0000001, exp_in=5 → done at T+5; mant_out=0x000010, exp_out=0, underflow=1.
- Overflow: mant_in=0x1000000, exp_in=254 → done at T+2; exp_out=255, mant_out=0, overflow=1.
- Zero input, busy start and reset:
  - mant_in=0, exp_in=90 → done at T+1; zero=1, exp_out=0.
  - A second start pulsed while ready=0 is ignored.
  - rst asserted mid-SHIFT → ready=1 and all outputs=0 immediately; no done pulse follows.
